// File: rtl/data_memory_controller.sv
// Single-port data memory arbiter: the interrupt unit has priority over the pipeline.
// Each granted request becomes one or two 16-bit accesses; the owner sees a one-cycle done pulse.
module data_memory_controller #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_p_req,
    input  logic                    i_p_write,
    input  logic                    i_p_double,
    input  logic [ADDR_WIDTH-1:0]   i_p_address,
    input  logic [2*DATA_WIDTH-1:0] i_p_write_data,
    output logic                    o_p_done,
    output logic [2*DATA_WIDTH-1:0] o_p_read_data,
    output logic                    o_p_stall,
    input  logic                    i_i_req,
    input  logic                    i_i_write,
    input  logic                    i_i_double,
    input  logic [ADDR_WIDTH-1:0]   i_i_address,
    input  logic [2*DATA_WIDTH-1:0] i_i_write_data,
    output logic                    o_i_done,
    output logic [2*DATA_WIDTH-1:0] o_i_read_data,
    output logic                    o_i_stall,
    output logic [ADDR_WIDTH-1:0]   o_mem_address,
    output logic [DATA_WIDTH-1:0]   o_mem_write_data,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    input  logic [DATA_WIDTH-1:0]   i_mem_read_data,
    output logic [2:0]              o_dbg_state
);

    // Handshake: a requester raises req with stable fields and holds it until its done
    // pulse; fields are latched at grant, and req still high in the following IDLE is a new request.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC0 = 3'd1,
        ACC1 = 3'd2,
        CAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                  state;
    logic                    own_i;
    logic                    wr;
    logic                    dbl;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [2*DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0]   res_lo;

    logic                    sel_write;
    logic                    sel_double;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [2*DATA_WIDTH-1:0] sel_wd;
    logic [2*DATA_WIDTH-1:0] cap_result;

    assign sel_write  = i_i_req ? i_i_write      : i_p_write;
    assign sel_double = i_i_req ? i_i_double     : i_p_double;
    assign sel_addr   = i_i_req ? i_i_address    : i_p_address;
    assign sel_wd     = i_i_req ? i_i_write_data : i_p_write_data;

    assign cap_result = dbl ? {i_mem_read_data, res_lo}
                            : {{DATA_WIDTH{1'b0}}, i_mem_read_data};

    assign o_p_stall   = i_p_req && !o_p_done;
    assign o_i_stall   = i_i_req && !o_i_done;
    assign o_dbg_state = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            own_i            <= 1'b0;
            wr               <= 1'b0;
            dbl              <= 1'b0;
            addr             <= '0;
            wd               <= '0;
            res_lo           <= '0;
            o_mem_address    <= '0;
            o_mem_write_data <= '0;
            o_mem_read       <= 1'b0;
            o_mem_write      <= 1'b0;
            o_p_done         <= 1'b0;
            o_i_done         <= 1'b0;
            o_p_read_data    <= '0;
            o_i_read_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_i_req || i_p_req) begin
                        own_i            <= i_i_req;
                        wr               <= sel_write;
                        dbl              <= sel_double;
                        addr             <= sel_addr;
                        wd               <= sel_wd;
                        o_mem_address    <= sel_addr;
                        o_mem_write_data <= sel_wd[DATA_WIDTH-1:0];
                        o_mem_write      <= sel_write;
                        o_mem_read       <= !sel_write;
                        state            <= ACC0;
                    end
                end
                ACC0: begin
                    if (dbl) begin
                        // Read/write enables stay as set for the second word.
                        o_mem_address    <= addr + ADDR_WIDTH'(1);
                        o_mem_write_data <= wd[2*DATA_WIDTH-1:DATA_WIDTH];
                        state            <= ACC1;
                    end else begin
                        o_mem_read  <= 1'b0;
                        o_mem_write <= 1'b0;
                        if (wr) begin
                            o_i_done <= own_i;
                            o_p_done <= !own_i;
                            state    <= DONE;
                        end else begin
                            state <= CAP;
                        end
                    end
                end
                ACC1: begin
                    o_mem_read  <= 1'b0;
                    o_mem_write <= 1'b0;
                    if (wr) begin
                        o_i_done <= own_i;
                        o_p_done <= !own_i;
                        state    <= DONE;
                    end else begin
                        res_lo <= i_mem_read_data;
                        state  <= CAP;
                    end
                end
                CAP: begin
                    if (own_i) o_i_read_data <= cap_result;
                    else       o_p_read_data <= cap_result;
                    o_i_done <= own_i;
                    o_p_done <= !own_i;
                    state    <= DONE;
                end
                DONE: begin
                    o_p_done <= 1'b0;
                    o_i_done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_controller.sv
// Bench for data_memory_controller: directed and random transactions against a
// word-addressed reference memory with latency and read-data expectations.
module tb_data_memory_controller;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_p_req = 1'b0, i_p_write = 1'b0, i_p_double = 1'b0;
    logic [15:0] i_p_address = '0;
    logic [31:0] i_p_write_data = '0;
    logic        o_p_done, o_p_stall;
    logic [31:0] o_p_read_data;
    logic        i_i_req = 1'b0, i_i_write = 1'b0, i_i_double = 1'b0;
    logic [15:0] i_i_address = '0;
    logic [31:0] i_i_write_data = '0;
    logic        o_i_done, o_i_stall;
    logic [31:0] o_i_read_data;
    logic [15:0] o_mem_address, o_mem_write_data;
    logic        o_mem_read, o_mem_write;
    logic [15:0] i_mem_read_data = '0;
    logic [2:0]  dbg_state;

    int checks = 0;
    int passes = 0;
    int both_hi = 0;

    data_memory_controller #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_p_req(i_p_req), .i_p_write(i_p_write), .i_p_double(i_p_double),
        .i_p_address(i_p_address), .i_p_write_data(i_p_write_data),
        .o_p_done(o_p_done), .o_p_read_data(o_p_read_data), .o_p_stall(o_p_stall),
        .i_i_req(i_i_req), .i_i_write(i_i_write), .i_i_double(i_i_double),
        .i_i_address(i_i_address), .i_i_write_data(i_i_write_data),
        .o_i_done(o_i_done), .o_i_read_data(o_i_read_data), .o_i_stall(o_i_stall),
        .o_mem_address(o_mem_address), .o_mem_write_data(o_mem_write_data),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .i_mem_read_data(i_mem_read_data), .o_dbg_state(dbg_state)
    );

    // clock
    always #5 i_clk = ~i_clk;

    // data memory device: one-cycle read latency, unwritten words hold a fixed pattern
    logic [15:0] dev_mem [int];

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    always @(posedge i_clk) begin
        if (o_mem_read)
            i_mem_read_data <= dev_mem.exists(int'(o_mem_address)) ? dev_mem[int'(o_mem_address)]
                                                                   : init_word(o_mem_address);
        if (o_mem_write)
            dev_mem[int'(o_mem_address)] = o_mem_write_data;
    end

    always @(negedge i_clk)
        if (o_mem_read && o_mem_write) both_hi++;

    // reference model
    logic [15:0] ref_mem [int];
    logic [31:0] exp_rd_p = '0;
    logic [31:0] exp_rd_i = '0;

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    function automatic int lat(input bit w, input bit d);
        return w ? (d ? 3 : 2) : (d ? 4 : 3);
    endfunction

    task automatic model_apply(input bit src, input bit w, input bit d,
                               input logic [15:0] a, input logic [31:0] wd);
        logic [15:0] a1;
        logic [31:0] r;
        a1 = a + 16'd1;
        if (w) begin
            ref_mem[int'(a)] = wd[15:0];
            if (d) ref_mem[int'(a1)] = wd[31:16];
        end else begin
            r = d ? {ref_rd(a1), ref_rd(a)} : {16'h0000, ref_rd(a)};
            if (src) exp_rd_i = r;
            else     exp_rd_p = r;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // drivers
    task automatic drive(input bit src, input bit w, input bit d,
                         input logic [15:0] a, input logic [31:0] wd);
        if (src) begin
            i_i_req = 1'b1; i_i_write = w; i_i_double = d; i_i_address = a; i_i_write_data = wd;
        end else begin
            i_p_req = 1'b1; i_p_write = w; i_p_double = d; i_p_address = a; i_p_write_data = wd;
        end
    endtask

    task automatic run_txn(input bit src, input bit w, input bit d,
                           input logic [15:0] a, input logic [31:0] wd);
        int n;
        bit got, other_seen, stall_ok;
        n = 0; got = 0; other_seen = 0; stall_ok = 1;
        @(posedge i_clk); #1;
        drive(src, w, d, a, wd);
        while (!got && n < 20) begin
            @(posedge i_clk);
            @(negedge i_clk);
            n++;
            if (src ? o_p_done : o_i_done) other_seen = 1;
            if (src ? o_i_done : o_p_done) got = 1;
            else if (!(src ? o_i_stall : o_p_stall)) stall_ok = 0;
        end
        check(src ? "i_done_latency" : "p_done_latency", n, lat(w, d));
        check("stall_while_pending", stall_ok, 1);
        check("other_done_quiet", other_seen, 0);
        check("stall_at_done", src ? o_i_stall : o_p_stall, 0);
        if (src) i_i_req = 1'b0; else i_p_req = 1'b0;
        model_apply(src, w, d, a, wd);
        check("p_read_data", o_p_read_data, exp_rd_p);
        check("i_read_data", o_i_read_data, exp_rd_i);
    endtask

    task automatic run_both(input bit pw, input bit pd, input logic [15:0] pa, input logic [31:0] pwd,
                            input bit iw, input bit id, input logic [15:0] ia, input logic [31:0] iwd);
        int n, p_cyc, i_cyc;
        bit p_stall_ok;
        n = 0; p_cyc = -1; i_cyc = -1; p_stall_ok = 1;
        @(posedge i_clk); #1;
        drive(1'b1, iw, id, ia, iwd);
        drive(1'b0, pw, pd, pa, pwd);
        while (p_cyc < 0 && n < 30) begin
            @(posedge i_clk);
            @(negedge i_clk);
            n++;
            if (o_i_done && i_cyc < 0) begin
                i_cyc = n;
                i_i_req = 1'b0;
                model_apply(1'b1, iw, id, ia, iwd);
                check("both_i_read_data", o_i_read_data, exp_rd_i);
            end
            if (o_p_done) begin
                p_cyc = n;
                i_p_req = 1'b0;
                model_apply(1'b0, pw, pd, pa, pwd);
                check("both_p_read_data", o_p_read_data, exp_rd_p);
            end else if (!o_p_stall) p_stall_ok = 0;
        end
        check("both_i_latency", i_cyc, lat(iw, id));
        check("both_p_latency", p_cyc, lat(iw, id) + 1 + lat(pw, pd));
        check("both_p_stall", p_stall_ok, 1);
    endtask

    initial begin
        logic [15:0] a;
        // reset state
        #12;
        check("rst_mem_read", o_mem_read, 0);
        check("rst_mem_write", o_mem_write, 0);
        check("rst_p_done", o_p_done, 0);
        check("rst_i_done", o_i_done, 0);
        check("rst_mem_address", o_mem_address, 0);
        check("rst_mem_write_data", o_mem_write_data, 0);
        check("rst_p_read_data", o_p_read_data, 0);
        check("rst_i_read_data", o_i_read_data, 0);
        check("rst_dbg_state_idle", dbg_state, 0);
        @(negedge i_clk); i_rst_n = 1'b1;
        check("idle_p_stall", o_p_stall, 0);

        // pipeline single write then read
        run_txn(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0000_0A00);
        run_txn(1'b0, 1'b0, 1'b0, 16'h0010, 32'h0);
        check("p_single_read_value", o_p_read_data, 32'h0000_0A00);

        // interrupt double write then read
        run_txn(1'b1, 1'b1, 1'b1, 16'h0FFE, 32'h1234_5678);
        check("dev_mem_0ffe", dev_mem.exists(32'h0FFE) ? {16'h0, dev_mem[32'h0FFE]} : 32'hDEAD, 32'h5678);
        check("dev_mem_0fff", dev_mem.exists(32'h0FFF) ? {16'h0, dev_mem[32'h0FFF]} : 32'hDEAD, 32'h1234);
        run_txn(1'b1, 1'b0, 1'b1, 16'h0FFE, 32'h0);
        check("i_double_read_value", o_i_read_data, 32'h1234_5678);

        // simultaneous requests
        run_both(1'b0, 1'b0, 16'h0020, 32'h0, 1'b1, 1'b1, 16'h0100, 32'hCAFE_F00D);

        // double write wrapping at the top of the address space
        @(posedge i_clk); #1;
        drive(1'b0, 1'b1, 1'b1, 16'hFFFF, 32'hAAAA_5555);
        @(posedge i_clk); @(negedge i_clk);
        check("wrap_acc0_addr", o_mem_address, 16'hFFFF);
        check("wrap_acc0_data", o_mem_write_data, 16'h5555);
        @(posedge i_clk); @(negedge i_clk);
        check("wrap_acc1_addr", o_mem_address, 16'h0000);
        check("wrap_acc1_data", o_mem_write_data, 16'hAAAA);
        check("wrap_acc1_write", {o_mem_write, o_mem_read}, 2'b10);
        @(posedge i_clk); @(negedge i_clk);
        check("wrap_done", o_p_done, 1);
        i_p_req = 1'b0;
        model_apply(1'b0, 1'b1, 1'b1, 16'hFFFF, 32'hAAAA_5555);
        run_txn(1'b1, 1'b0, 1'b1, 16'hFFFF, 32'h0);

        // asynchronous reset in the middle of a double write
        @(posedge i_clk); #1;
        drive(1'b1, 1'b1, 1'b1, 16'h0200, 32'hBEEF_CAFE);
        @(posedge i_clk); @(posedge i_clk); @(negedge i_clk);
        check("pre_rst_acc1_addr", o_mem_address, 16'h0201);
        #2 i_rst_n = 1'b0;
        #1;
        check("mid_rst_controls", {o_mem_read, o_mem_write, o_p_done, o_i_done}, 4'b0000);
        check("mid_rst_addr", o_mem_address, 0);
        check("mid_rst_read_data", {o_p_read_data | o_i_read_data}, 0);
        i_i_req = 1'b0;
        ref_mem[32'h0200] = 16'hCAFE;
        exp_rd_p = '0;
        exp_rd_i = '0;
        @(negedge i_clk); i_rst_n = 1'b1;
        run_txn(1'b0, 1'b0, 1'b1, 16'h0200, 32'h0);
        check("post_rst_partial_write", o_p_read_data, {init_word(16'h0201), 16'hCAFE});

        // random single-requester transactions around a small wrapping window
        for (int k = 0; k < 30; k++) begin
            a = 16'(32'hFFFC + $urandom_range(0, 7));
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    a, $urandom);
        end
        // random simultaneous requests
        for (int k = 0; k < 6; k++) begin
            run_both(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'(32'hFFFC + $urandom_range(0, 7)), $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'(32'hFFFC + $urandom_range(0, 7)), $urandom);
        end

        check("read_write_never_both", both_hi, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
